// File: rtl/multicycle_alu_if.sv
// Operation/result handshake bundle for multicycle_alu: the operation channel
// flows master->slave, the result channel flows slave->master.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       ALUCtrl_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             Zero_o;

  modport slave (
    input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
    output ready_o, valid_o, data_o, Zero_o
  );

  modport master (
    output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
    input  ready_o, valid_o, data_o, Zero_o
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/add/sub, iterative shift-add multiply and,
// when MULTICYCLE_ALU_DIV_EN is defined, iterative restoring divide/remainder.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  multicycle_alu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REMU = 3'b110;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             zero_reg, zero_next;

  logic [WIDTH-1:0] simple_result;
  logic [WIDTH-1:0] mul_sum;
  logic             last_iter;

  always_comb begin
    simple_result = '0;
    case (bus.ALUCtrl_i)
      OP_AND:  simple_result = bus.data1_i & bus.data2_i;
      OP_OR:   simple_result = bus.data1_i | bus.data2_i;
      OP_ADD:  simple_result = bus.data1_i + bus.data2_i;
      OP_SUB:  simple_result = bus.data1_i - bus.data2_i;
      default: simple_result = '0;
    endcase
  end

  // a_reg shifts left as the multiplicand, b_reg shifts right exposing multiplier bits.
  assign mul_sum   = acc_reg + (b_reg[0] ? a_reg : '0);
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

`ifdef MULTICYCLE_ALU_DIV_EN
  // Division reuses acc_reg as the partial remainder and a_reg as dividend/quotient.
  logic             rem_sel_reg, rem_sel_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quot;

  assign div_shift = {acc_reg, a_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign div_fits  = ~div_diff[WIDTH];
  assign div_rem   = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quot  = {a_reg[WIDTH-2:0], div_fits};
`endif

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    zero_next  = zero_reg;
`ifdef MULTICYCLE_ALU_DIV_EN
    rem_sel_next = rem_sel_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.valid_i) begin
          a_next    = bus.data1_i;
          b_next    = bus.data2_i;
          acc_next  = '0;
          cnt_next  = '0;
          zero_next = (bus.data1_i == bus.data2_i);
          case (bus.ALUCtrl_i)
            OP_MUL: state_next = MUL;
`ifdef MULTICYCLE_ALU_DIV_EN
            OP_DIVU, OP_REMU: begin
              rem_sel_next = (bus.ALUCtrl_i == OP_REMU);
              if (bus.data2_i == '0) begin
                data_next  = (bus.ALUCtrl_i == OP_REMU) ? bus.data1_i : '1;
                state_next = DONE;
              end else begin
                state_next = DIV;
              end
            end
`endif
            default: begin
              data_next  = simple_result;
              state_next = DONE;
            end
          endcase
        end
      end
      MUL: begin
        acc_next = mul_sum;
        a_next   = a_reg << 1;
        b_next   = b_reg >> 1;
        cnt_next = cnt_reg + CW'(1);
        if (last_iter) begin
          data_next  = mul_sum;
          state_next = DONE;
        end
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      DIV: begin
        acc_next = div_rem;
        a_next   = div_quot;
        cnt_next = cnt_reg + CW'(1);
        if (last_iter) begin
          data_next  = rem_sel_reg ? div_rem : div_quot;
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        if (bus.ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      zero_reg  <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
      rem_sel_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      zero_reg  <= zero_next;
`ifdef MULTICYCLE_ALU_DIV_EN
      rem_sel_reg <= rem_sel_next;
`endif
    end
  end

  assign bus.ready_o = (state_reg == IDLE);
  assign bus.valid_o = (state_reg == DONE);
  assign bus.data_o  = data_reg;
  assign bus.Zero_o  = zero_reg;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (WIDTH=32) with an expected-result queue;
// divider checks follow MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    int           lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0] p;
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b011: return a - b;
      3'b100: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
`ifdef MULTICYCLE_ALU_DIV_EN
      3'b101: return (b == 0) ? {W{1'b1}} : a / b;
      3'b110: return (b == 0) ? a : a % b;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic int lat_model(input logic [2:0] op, input logic [W-1:0] b);
    if (op == 3'b100) return W + 1;
`ifdef MULTICYCLE_ALU_DIV_EN
    if ((op == 3'b101 || op == 3'b110) && b != 0) return W + 1;
`endif
    return 1;
  endfunction

  // Offers one operation, queues its expectation, returns just after the accept edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    chk("ready_before_accept", bus.ready_o, 1);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    e.data = model(op, a, b);
    e.zero = (a == b);
    e.lat  = lat_model(op, b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.valid_i   = 1'b0;
    bus.data1_i   = $urandom;
    bus.data2_i   = $urandom;
    bus.ALUCtrl_i = 3'($urandom);
  endtask

  task automatic wait_result(input string tag, output logic [W-1:0] got);
    int   lat;
    bit   rdy_low;
    exp_t e;
    lat = 0;
    rdy_low = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.valid_o && bus.ready_o) rdy_low = 1'b0;
    end while (!bus.valid_o && lat < 200);
    got = bus.data_o;
    e = sb.pop_front();
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_data"}, bus.data_o, e.data);
    chk({tag, "_zero"}, bus.Zero_o, e.zero);
    if (e.lat > 1) chk({tag, "_ready_low_while_busy"}, rdy_low, 1);
    $display("op %s: data_o=0x%0h Zero_o=%0b latency=%0d", tag, bus.data_o, bus.Zero_o, lat);
  endtask

  initial begin
    logic [W-1:0] got;
    bit           stable;
    bit           saw_valid;
    exp_t         e;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.valid_i   = 1'b0;
    bus.ready_i   = 1'b1;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    bus.ALUCtrl_i = '0;

    repeat (2) @(negedge clk);
    chk("reset_ready", bus.ready_o, 1);
    chk("reset_valid", bus.valid_o, 0);
    chk("reset_data", bus.data_o, 0);
    chk("reset_zero", bus.Zero_o, 0);
    rst_n = 1'b1;

    start_op(3'b010, 32'hFFFF_FFFF, 32'h1);  wait_result("add_wrap", got);
    start_op(3'b011, 32'd5, 32'd5);          wait_result("sub_equal", got);
    start_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00); wait_result("and", got);
    start_op(3'b001, 32'hA000_0005, 32'h0500_00A0); wait_result("or", got);
    start_op(3'b011, 32'd3, 32'd10);         wait_result("sub_wrap", got);
    start_op(3'b111, 32'd77, 32'd77);        wait_result("reserved", got);
    start_op(3'b100, 32'h0001_0000, 32'h0001_0003); wait_result("mul_big", got);
    start_op(3'b100, 32'd12345, 32'd6789);   wait_result("mul_small", got);
    start_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_result("mul_ones", got);
`ifdef MULTICYCLE_ALU_DIV_EN
    start_op(3'b101, 32'd100, 32'd7);        wait_result("divu", got);
    start_op(3'b110, 32'd100, 32'd7);        wait_result("remu", got);
    start_op(3'b101, 32'd9, 32'd0);          wait_result("divu_by0", got);
    start_op(3'b110, 32'd9, 32'd0);          wait_result("remu_by0", got);
    start_op(3'b101, 32'hDEAD_BEEF, 32'h1234); wait_result("divu_big", got);
    start_op(3'b110, 32'hDEAD_BEEF, 32'h1234); wait_result("remu_big", got);
`else
    start_op(3'b101, 32'd100, 32'd7);        wait_result("op101_reserved", got);
    start_op(3'b110, 32'd100, 32'd7);        wait_result("op110_reserved", got);
`endif

    // Backpressure: result must hold while ready_i is low.
    @(negedge clk);
    bus.ready_i = 1'b0;
    start_op(3'b001, 32'hF0F0_0000, 32'h0000_0F0F);
    wait_result("or_bp", got);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.valid_o === 1'b1 && bus.data_o === got)) stable = 1'b0;
    end
    chk("bp_hold_stable", stable, 1);
    bus.ready_i   = 1'b1;
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 3'b010;
    bus.data1_i   = 32'd7;
    bus.data2_i   = 32'd8;
    e.data = model(3'b010, 32'd7, 32'd8);
    e.zero = 1'b0;
    e.lat  = 1;
    sb.push_back(e);
    @(negedge clk);
    chk("bp_idle_after_handshake", bus.ready_o, 1);
    chk("bp_valid_dropped", bus.valid_o, 0);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    chk("bp_next_valid", bus.valid_o, 1);
    chk("bp_next_data", bus.data_o, e.data);
    $display("op bp_next_add: data_o=0x%0h valid_o=%0b", bus.data_o, bus.valid_o);

    // Reset in the middle of a multiply.
    start_op(3'b010, 32'h1234, 32'h1);       wait_result("add_pre_reset", got);
    start_op(3'b100, 32'hABCD, 32'h1234);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midmul_reset_ready", bus.ready_o, 1);
    chk("midmul_reset_valid", bus.valid_o, 0);
    chk("midmul_reset_data", bus.data_o, 0);
    chk("midmul_reset_zero", bus.Zero_o, 0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) saw_valid = 1'b1;
    end
    chk("no_result_after_reset", saw_valid, 0);
    $display("op mul_reset: discarded, valid_o never raised=%0b", !saw_valid);
    start_op(3'b010, 32'd2, 32'd3);          wait_result("add_after_reset", got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
